// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: 2-bit predictor encodings, BTB entry layout and counter update.
package fetch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_ALLOC = WT;

  // Tag/target fields are sized for the widest supported address; narrower builds zero-extend.
  localparam int unsigned BTB_FIELD_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    ctr_e                   ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    unique case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      default: nxt = taken ? ST  : WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: execute redirect/BTB training, instruction memory and decode-facing outputs.
interface fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) ();

  logic              hold;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              btb_upd_valid;
  logic [ADDR_W-1:0] btb_upd_pc;
  logic              btb_upd_taken;
  logic [ADDR_W-1:0] btb_upd_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic [DATA_W-1:0] if_instr;
  logic              if_valid;
  logic              if_pred_taken;
  logic [ADDR_W-1:0] if_pred_target;

  modport slave (
    input  hold, redirect_valid, redirect_target,
    input  btb_upd_valid, btb_upd_pc, btb_upd_taken, btb_upd_target,
    input  imem_rdata,
    output imem_addr,
    output if_pc, if_pc_plus1, if_instr, if_valid, if_pred_taken, if_pred_target
  );

  modport master (
    output hold, redirect_valid, redirect_target,
    output btb_upd_valid, btb_upd_pc, btb_upd_taken, btb_upd_target,
    output imem_rdata,
    input  imem_addr,
    input  if_pc, if_pc_plus1, if_instr, if_valid, if_pred_taken, if_pred_target
  );

endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating taken counters.
// Lookup is combinational; updates land on the clock edge, so same-cycle lookups see old contents.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_lk_pc,
  output logic              o_lk_taken,
  output logic [ADDR_W-1:0] o_lk_target,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  btb_entry_t r_mem [BTB_ENTRIES];

  logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
  logic [TAG_W-1:0] w_lk_tag, w_upd_tag;
  btb_entry_t       w_lk_ent, w_upd_ent;
  logic             w_lk_hit, w_upd_hit;
  logic             w_unused;

  assign w_lk_idx  = i_lk_pc[IDX_W-1:0];
  assign w_lk_tag  = i_lk_pc[ADDR_W-1:IDX_W];
  assign w_upd_idx = i_upd_pc[IDX_W-1:0];
  assign w_upd_tag = i_upd_pc[ADDR_W-1:IDX_W];

  assign w_lk_ent  = r_mem[w_lk_idx];
  assign w_upd_ent = r_mem[w_upd_idx];

  assign w_lk_hit  = w_lk_ent.valid && (w_lk_ent.tag == BTB_FIELD_W'(w_lk_tag));
  assign w_upd_hit = w_upd_ent.valid && (w_upd_ent.tag == BTB_FIELD_W'(w_upd_tag));

  assign o_lk_taken  = w_lk_hit & w_lk_ent.ctr[1];
  assign o_lk_target = o_lk_taken ? w_lk_ent.target[ADDR_W-1:0] : '0;

  // Upper target bits are always zero and the counter LSB does not affect the prediction.
  assign w_unused = ^{w_lk_ent.target, w_lk_ent.ctr, w_upd_ent.target};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_mem[w_upd_idx].ctr <= ctr_next(w_upd_ent.ctr, i_upd_taken);
        if (i_upd_taken) begin
          r_mem[w_upd_idx].target <= BTB_FIELD_W'(i_upd_target);
        end
      end else if (i_upd_taken) begin
        r_mem[w_upd_idx] <= '{valid:  1'b1,
                              tag:    BTB_FIELD_W'(w_upd_tag),
                              target: BTB_FIELD_W'(i_upd_target),
                              ctr:    CTR_ALLOC};
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection (redirect > hold > BTB > sequential), start-up
// bubble and decode valid logic around a 1-cycle synchronous instruction memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_started;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic [DATA_W-1:0] w_instr;

  fetch_btb #(
    .ADDR_W     (ADDR_W),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_lk_pc     (r_pc),
    .o_lk_taken  (w_pred_taken),
    .o_lk_target (w_pred_target),
    .i_upd_valid (bus.btb_upd_valid),
    .i_upd_pc    (bus.btb_upd_pc),
    .i_upd_taken (bus.btb_upd_taken),
    .i_upd_target(bus.btb_upd_target)
  );

  // Memory is addressed by the next PC so its registered output lines up with r_pc.
  always_comb begin
    w_next_pc = r_pc + ADDR_W'(1);
    if (rst) begin
      w_next_pc = RESET_PC;
    end else if (!r_started) begin
      w_next_pc = r_pc;
    end else if (bus.redirect_valid) begin
      w_next_pc = bus.redirect_target;
    end else if (bus.hold) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_started <= 1'b0;
    end else begin
      r_pc      <= w_next_pc;
      r_started <= 1'b1;
    end
  end

  assign w_instr = bus.imem_rdata;

  assign bus.imem_addr      = w_next_pc;
  assign bus.if_pc          = r_pc;
  assign bus.if_pc_plus1    = r_pc + ADDR_W'(1);
  assign bus.if_instr       = w_instr;
  assign bus.if_valid       = r_started & ~bus.redirect_valid & ~rst;
  assign bus.if_pred_taken  = w_pred_taken;
  assign bus.if_pred_target = w_pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, hold, redirect, BTB training/aliasing, wrap, reset.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

  fetch_unit #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BTB_ENTRIES(16),
    .RESET_PC   ('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  always @(posedge clk) u_if.imem_rdata <= mem_word(u_if.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.hold            = 1'b0;
    u_if.redirect_valid  = 1'b0;
    u_if.redirect_target = '0;
    u_if.btb_upd_valid   = 1'b0;
    u_if.btb_upd_pc      = '0;
    u_if.btb_upd_taken   = 1'b0;
    u_if.btb_upd_target  = '0;
  endtask

  task automatic redirect_to(input logic [ADDR_W-1:0] tgt);
    u_if.redirect_valid  = 1'b1;
    u_if.redirect_target = tgt;
    step();
    u_if.redirect_valid  = 1'b0;
    #1;
  endtask

  task automatic btb_update(input logic [ADDR_W-1:0] pc, input logic taken,
                            input logic [ADDR_W-1:0] tgt);
    u_if.btb_upd_valid  = 1'b1;
    u_if.btb_upd_pc     = pc;
    u_if.btb_upd_taken  = taken;
    u_if.btb_upd_target = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    n_total++;
    if (u_if.imem_addr !== 10'd0) $display("FAIL reset_addr: got %0h want 0", u_if.imem_addr);
    else n_pass++;
    n_total++;
    if (u_if.if_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", u_if.if_valid);
    else n_pass++;
    n_total++;
    if (u_if.if_pred_taken !== 1'b0) $display("FAIL reset_pred: got %0b want 0", u_if.if_pred_taken);
    else n_pass++;
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    #1;
    n_total++;
    if (u_if.if_valid !== 1'b0) $display("FAIL startup_valid: got %0b want 0", u_if.if_valid);
    else n_pass++;
    n_total++;
    if (u_if.imem_addr !== 10'd0) $display("FAIL startup_addr: got %0h want 0", u_if.imem_addr);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (u_if.if_valid !== 1'b1 || u_if.if_pc !== ADDR_W'(i))
        $display("FAIL seq_pc: got pc %0h valid %0b want pc %0h valid 1",
                 u_if.if_pc, u_if.if_valid, i);
      else n_pass++;
      n_total++;
      if (u_if.if_pc_plus1 !== ADDR_W'(i + 1))
        $display("FAIL seq_plus1: got %0h want %0h", u_if.if_pc_plus1, i + 1);
      else n_pass++;
      n_total++;
      if (u_if.if_instr !== mem_word(ADDR_W'(i)))
        $display("FAIL seq_instr: got %0h want %0h", u_if.if_instr, mem_word(ADDR_W'(i)));
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    step();
    step();
    u_if.hold = 1'b1;
    #1;
    n_total++;
    if (u_if.imem_addr !== 10'd5) $display("FAIL hold_addr: got %0h want 5", u_if.imem_addr);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step();
      n_total++;
      if (u_if.if_pc !== 10'd5 || u_if.if_instr !== mem_word(10'd5) || u_if.if_valid !== 1'b1 ||
          u_if.imem_addr !== 10'd5)
        $display("FAIL hold_stable: got pc %0h instr %0h valid %0b addr %0h want pc 5 valid 1",
                 u_if.if_pc, u_if.if_instr, u_if.if_valid, u_if.imem_addr);
      else n_pass++;
    end
    u_if.hold = 1'b0;
    #1;
    n_total++;
    if (u_if.imem_addr !== 10'd6) $display("FAIL hold_release_addr: got %0h want 6", u_if.imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (u_if.if_pc !== 10'd6 || u_if.if_instr !== mem_word(10'd6))
      $display("FAIL hold_resume: got pc %0h instr %0h want pc 6", u_if.if_pc, u_if.if_instr);
    else n_pass++;
  endtask

  task automatic test_redirect();
    step();
    u_if.hold            = 1'b1;
    u_if.redirect_valid  = 1'b1;
    u_if.redirect_target = 10'h100;
    #1;
    n_total++;
    if (u_if.if_pc !== 10'd7 || u_if.if_valid !== 1'b0 || u_if.imem_addr !== 10'h100)
      $display("FAIL redirect_squash: got pc %0h valid %0b addr %0h want pc 7 valid 0 addr 100",
               u_if.if_pc, u_if.if_valid, u_if.imem_addr);
    else n_pass++;
    step();
    clear_inputs();
    #1;
    n_total++;
    if (u_if.if_pc !== 10'h100 || u_if.if_valid !== 1'b1 || u_if.if_instr !== mem_word(10'h100))
      $display("FAIL redirect_target: got pc %0h valid %0b instr %0h want pc 100 valid 1",
               u_if.if_pc, u_if.if_valid, u_if.if_instr);
    else n_pass++;
  endtask

  task automatic test_btb_train();
    btb_update(10'd4, 1'b1, 10'd20);
    redirect_to(10'd2);
    clear_inputs();
    #1;
    n_total++;
    if (u_if.if_pc !== 10'd2 || u_if.if_pred_taken !== 1'b0 || u_if.if_pred_target !== 10'd0)
      $display("FAIL train_pc2: got pc %0h pred %0b tgt %0h want pc 2 pred 0 tgt 0",
               u_if.if_pc, u_if.if_pred_taken, u_if.if_pred_target);
    else n_pass++;
    step();
    step();
    n_total++;
    if (u_if.if_pc !== 10'd4 || u_if.if_pred_taken !== 1'b1 || u_if.if_pred_target !== 10'd20 ||
        u_if.imem_addr !== 10'd20)
      $display("FAIL train_hit: got pc %0h pred %0b tgt %0h addr %0h want pc 4 pred 1 tgt 14",
               u_if.if_pc, u_if.if_pred_taken, u_if.if_pred_target, u_if.imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (u_if.if_pc !== 10'd20 || u_if.if_valid !== 1'b1)
      $display("FAIL train_follow: got pc %0h valid %0b want pc 14", u_if.if_pc, u_if.if_valid);
    else n_pass++;
    // Two not-taken updates: counter 2 -> 1 -> 0.
    btb_update(10'd4, 1'b0, 10'd0);
    step();
    redirect_to(10'd4);
    clear_inputs();
    #1;
    n_total++;
    if (u_if.if_pred_taken !== 1'b0 || u_if.imem_addr !== 10'd5)
      $display("FAIL train_nt: got pred %0b addr %0h want pred 0 addr 5",
               u_if.if_pred_taken, u_if.imem_addr);
    else n_pass++;
    // One taken update from 0 reaches 1, which must still predict not-taken.
    btb_update(10'd4, 1'b1, 10'd20);
    step();
    clear_inputs();
    redirect_to(10'd4);
    n_total++;
    if (u_if.if_pc !== 10'd4 || u_if.if_pred_taken !== 1'b0)
      $display("FAIL train_ctr1: got pc %0h pred %0b want pc 4 pred 0", u_if.if_pc, u_if.if_pred_taken);
    else n_pass++;
    btb_update(10'd4, 1'b1, 10'd20);
    #1;
    n_total++;
    if (u_if.if_pred_taken !== 1'b0 || u_if.imem_addr !== 10'd5)
      $display("FAIL rbw_old_nt: got pred %0b addr %0h want pred 0 addr 5",
               u_if.if_pred_taken, u_if.imem_addr);
    else n_pass++;
    step();
    clear_inputs();
    redirect_to(10'd4);
    n_total++;
    if (u_if.if_pred_taken !== 1'b1 || u_if.if_pred_target !== 10'd20)
      $display("FAIL train_ctr2: got pred %0b tgt %0h want pred 1 tgt 14",
               u_if.if_pred_taken, u_if.if_pred_target);
    else n_pass++;
    btb_update(10'd4, 1'b0, 10'd0);
    #1;
    n_total++;
    if (u_if.if_pred_taken !== 1'b1 || u_if.imem_addr !== 10'd20)
      $display("FAIL rbw_old_t: got pred %0b addr %0h want pred 1 addr 14",
               u_if.if_pred_taken, u_if.imem_addr);
    else n_pass++;
    step();
    clear_inputs();
    #1;
  endtask

  task automatic test_alias();
    btb_update(10'd3, 1'b1, 10'd40);
    redirect_to(10'd3);
    clear_inputs();
    #1;
    n_total++;
    if (u_if.if_pc !== 10'd3 || u_if.if_pred_taken !== 1'b1 || u_if.if_pred_target !== 10'd40 ||
        u_if.imem_addr !== 10'd40)
      $display("FAIL alias_first: got pc %0h pred %0b tgt %0h addr %0h want pc 3 pred 1 tgt 28",
               u_if.if_pc, u_if.if_pred_taken, u_if.if_pred_target, u_if.imem_addr);
    else n_pass++;
    btb_update(10'd19, 1'b1, 10'd50);
    #1;
    n_total++;
    if (u_if.if_pred_taken !== 1'b1 || u_if.if_pred_target !== 10'd40)
      $display("FAIL alias_rbw: got pred %0b tgt %0h want pred 1 tgt 28",
               u_if.if_pred_taken, u_if.if_pred_target);
    else n_pass++;
    step();
    clear_inputs();
    redirect_to(10'd3);
    n_total++;
    if (u_if.if_pc !== 10'd3 || u_if.if_pred_taken !== 1'b0 || u_if.if_pred_target !== 10'd0 ||
        u_if.imem_addr !== 10'd4)
      $display("FAIL alias_evicted: got pc %0h pred %0b tgt %0h addr %0h want pc 3 pred 0 addr 4",
               u_if.if_pc, u_if.if_pred_taken, u_if.if_pred_target, u_if.imem_addr);
    else n_pass++;
    redirect_to(10'd19);
    n_total++;
    if (u_if.if_pc !== 10'd19 || u_if.if_pred_taken !== 1'b1 || u_if.if_pred_target !== 10'd50)
      $display("FAIL alias_second: got pc %0h pred %0b tgt %0h want pc 13 pred 1 tgt 32",
               u_if.if_pc, u_if.if_pred_taken, u_if.if_pred_target);
    else n_pass++;
  endtask

  task automatic test_wrap();
    redirect_to(10'h3FE);
    n_total++;
    if (u_if.if_pc !== 10'h3FE || u_if.if_valid !== 1'b1)
      $display("FAIL wrap_start: got pc %0h valid %0b want pc 3fe", u_if.if_pc, u_if.if_valid);
    else n_pass++;
    step();
    n_total++;
    if (u_if.if_pc !== 10'h3FF || u_if.if_pc_plus1 !== 10'd0 || u_if.imem_addr !== 10'd0)
      $display("FAIL wrap_top: got pc %0h plus1 %0h addr %0h want pc 3ff plus1 0 addr 0",
               u_if.if_pc, u_if.if_pc_plus1, u_if.imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (u_if.if_pc !== 10'd0 || u_if.if_valid !== 1'b1 || u_if.if_instr !== mem_word(10'd0))
      $display("FAIL wrap_zero: got pc %0h valid %0b instr %0h want pc 0 valid 1",
               u_if.if_pc, u_if.if_valid, u_if.if_instr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    btb_update(10'd4, 1'b1, 10'd20);
    #1;
    n_total++;
    if (u_if.if_valid !== 1'b0 || u_if.imem_addr !== 10'd0)
      $display("FAIL midrst_assert: got valid %0b addr %0h want valid 0 addr 0",
               u_if.if_valid, u_if.imem_addr);
    else n_pass++;
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_total++;
    if (u_if.if_valid !== 1'b0 || u_if.if_pc !== 10'd0)
      $display("FAIL midrst_bubble: got valid %0b pc %0h want valid 0 pc 0", u_if.if_valid, u_if.if_pc);
    else n_pass++;
    step();
    n_total++;
    if (u_if.if_valid !== 1'b1 || u_if.if_pc !== 10'd0)
      $display("FAIL midrst_restart: got valid %0b pc %0h want valid 1 pc 0", u_if.if_valid, u_if.if_pc);
    else n_pass++;
    redirect_to(10'd19);
    n_total++;
    if (u_if.if_pc !== 10'd19 || u_if.if_pred_taken !== 1'b0)
      $display("FAIL midrst_flushed: got pc %0h pred %0b want pc 13 pred 0",
               u_if.if_pc, u_if.if_pred_taken);
    else n_pass++;
    redirect_to(10'd4);
    n_total++;
    if (u_if.if_pc !== 10'd4 || u_if.if_pred_taken !== 1'b0 || u_if.imem_addr !== 10'd5)
      $display("FAIL midrst_upd_dropped: got pc %0h pred %0b addr %0h want pc 4 pred 0 addr 5",
               u_if.if_pc, u_if.if_pred_taken, u_if.imem_addr);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect();
    test_btb_train();
    test_alias();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit taken predictors.
- Generates the next PC and drives a synchronous instruction memory (1-cycle read latency) addressed by next-PC.
- Presents PC, PC+1, instruction and prediction info to decode through a valid/hold interface.
- Takes one unified redirect (resolved branch / jump / jr) from execute.

Parameters:
ADDR_W, 10, instruction address width (word addressed)
DATA_W, 32, instruction width
BTB_ENTRIES, 16, BTB entries; power of two, >= 2; IDX_W = log2(BTB_ENTRIES)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
hold  in  1  decode stall: freeze PC and IF outputs
redirect_valid  in  1  execute resolved a mispredict / jump / jr
redirect_target  in  ADDR_W  correct next PC
btb_upd_valid  in  1  execute reports a resolved control instruction
btb_upd_pc  in  ADDR_W  PC of that instruction
btb_upd_taken  in  1  actual direction
btb_upd_target  in  ADDR_W  actual taken target
imem_addr  out  ADDR_W  memory address (= next PC, combinational)
imem_rdata  in  DATA_W  memory data, for address presented last cycle
if_pc  out  ADDR_W  PC of instruction presented
if_pc_plus1  out  ADDR_W  if_pc + 1, wraps modulo 2^ADDR_W
if_instr  out  DATA_W  = imem_rdata
if_valid  out  1  if_instr is a live instruction
if_pred_taken  out  1  BTB predicted taken for if_pc
if_pred_target  out  ADDR_W  predicted target (0 when not taken)

Behaviour:
- State: pc_r (ADDR_W), started_r, the BTB arrays (valid, tag, target, 2-bit counter per entry).
- Reset (rst=1 at an edge):
  - pc_r <= RESET_PC; started_r <= 0; all BTB valid bits <= 0.
  - While rst=1: imem_addr = RESET_PC; if_valid = 0.
- Start-up cycle (started_r=0):
  - imem_addr = pc_r; pc_r holds; if_valid = 0; started_r <= 1.
  - Next cycle: if_valid=1, if_pc=RESET_PC, if_instr = mem[RESET_PC].
- Lookup is combinational on pc_r:
  - index = pc_r[IDX_W-1:0]; tag = pc_r[ADDR_W-1:IDX_W].
  - hit = valid & tag match.
  - pred_taken = hit & counter[1].
- Next-PC priority, highest first (applies when started_r=1):
  - rst: RESET_PC.
  - redirect_valid: redirect_target.
  - hold: pc_r.
  - pred_taken: BTB target.
  - otherwise: pc_r + 1.
- imem_addr = next PC every cycle; pc_r <= next PC.
- if_valid = started_r & ~redirect_valid & ~rst.
  - Redirect squashes the current wrong-path instruction in the same cycle.
  - Redirect overrides hold.
- Hold: pc_r unchanged and memory re-reads pc_r, so if_pc, if_instr and if_pred_* are stable for every hold cycle.
  - if_valid stays 1 during hold.
- Redirect latency: one bubble. The cycle after a redirect, if_pc = target and if_valid = 1.
- BTB update, applied at the edge when btb_upd_valid=1 (independent of hold/redirect):
  - Hit on btb_upd_pc: counter += 1 when taken, -= 1 when not, saturating at 3 / 0; target <= btb_upd_target when taken.
  - Miss and taken: allocate or overwrite the entry (valid=1, tag, target, counter=2).
  - Miss and not taken: no change.
- Update and lookup in the same cycle, same index: lookup uses the pre-update contents (read-before-write).
- rst asserted mid-stream: same-edge return to the reset state. BTB contents are invalidated, and pending updates that cycle are discarded.
- PC wrap: pc_r = 2^ADDR_W-1 sequentially advances to 0.

Decomposition:
- Package fetch_pkg holds:
  - counter encodings: SNT=0, WNT=1, WT=2, ST=3;
  - CTR_ALLOC = WT;
  - a btb_entry_t struct {valid, tag, target, ctr}.
- One sub-module, fetch_btb:
  - one combinational lookup port and one synchronous update port;
  - contains the storage array and the saturating-counter logic.
- fetch_unit keeps the next-PC mux, pc_r, started_r and the valid logic.

Test Plan:
1. Reset, then rst=0 with a sequential program → 1 bubble; if_pc runs 0,1,2,3 with if_valid=1 and if_pc_plus1 = if_pc+1; instructions match memory.
2. hold=1 for 3 cycles at if_pc=5 → imem_addr=5; if_pc/if_instr unchanged; if_valid=1; resumes at 6 on release.
3. redirect_valid with target 0x100 while if_pc=7, hold=1 → if_valid=0 that cycle; next cycle if_pc=0x100 and if_valid=1.
4. BTB training:
   - update pc=4, taken, target=20 → next visit to pc 4 gives if_pred_taken=1, if_pred_target=20, next if_pc=20;
   - two not-taken updates → counter goes 2→1→0 and prediction stops.
5. Aliasing, BTB_ENTRIES=16: entries at pc 3 and pc 19 → the later one overwrites the earlier; pc 3 then misses.
6. Update and lookup on the same index in the same cycle → old prediction used. Also run PC at 0x3FF with ADDR_W=10 and no branch → next if_pc=0; rst mid-run → if_valid=0 and the BTB reads empty.
